// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one clocked ALU between two valid/ready requesters, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority; round-robin otherwise.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_rd,
    input  logic             alu_z
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       owner, grant, accept, idle;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant = ~req0_valid;
`else
    logic last_grant;
    // On a tie the port that did not win last time is served
    assign grant = (req0_valid & req1_valid) ? ~last_grant : ~req0_valid;
`endif

    assign idle       = (state == IDLE) & rst_n;
    assign req0_ready = idle & req0_valid & ~grant;
    assign req1_ready = idle & req1_valid & grant;
    assign accept     = req0_ready | req1_ready;
    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) & owner;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ISSUE : IDLE;
            ISSUE:   state_nxt = (cnt == 3'd0) ? RESP : ISSUE;
            RESP:    state_nxt = (owner ? rsp1_ready : rsp0_ready) ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            owner    <= 1'b0;
            rsp_data <= '0;
            rsp_z    <= 1'b0;
            alu_rs1  <= '0;
            alu_rs2  <= '0;
            alu_ctrl <= 3'b000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner    <= grant;
                cnt      <= 3'(ALU_LAT);
                alu_ctrl <= grant ? req1_ctrl : req0_ctrl;
                alu_rs1  <= grant ? req1_a : req0_a;
                alu_rs2  <= grant ? req1_b : req0_b;
            end else if (state == ISSUE) begin
                if (cnt == 3'd0) begin
                    rsp_data <= alu_rd;
                    rsp_z    <= alu_z;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= 1'b1;
        else if (accept) last_grant <= grant;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus multi-cycle sequences against a one-cycle model ALU.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_z, alu_z;
    logic [2:0]   req0_ctrl = 0, req1_ctrl = 0, alu_ctrl;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [W-1:0] rsp_data, alu_rs1, alu_rs2, alu_rd;

    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_z(rsp_z),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl),
        .alu_rd(alu_rd), .alu_z(alu_z)
    );

    function automatic logic [W-1:0] alu_f(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        alu_rd <= alu_f(alu_ctrl, alu_rs1, alu_rs2);
        alu_z  <= alu_f(alu_ctrl, alu_rs1, alu_rs2) == '0;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic p, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p) begin
            req1_valid = 1; req1_ctrl = c; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1; req0_ctrl = c; req0_a = a; req0_b = b;
        end
    endtask

    typedef struct {
        logic         port;
        logic [2:0]   ctrl;
        logic [W-1:0] a, b, d;
        logic         z;
    } vec_t;

    task automatic do_op(input vec_t v, input string tag);
        int n, lat;
        @(negedge clk);
        drive_req(v.port, v.ctrl, v.a, v.b);
        #1;
        n = 0;
        while (!(v.port ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, " accept"}, W'(n < 20), 1);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        chk({tag, " alu_ctrl"}, W'(alu_ctrl), W'(v.ctrl));
        chk({tag, " alu_rs1"}, alu_rs1, v.a);
        chk({tag, " alu_rs2"}, alu_rs2, v.b);
        lat = 1;
        while (!(v.port ? rsp1_valid : rsp0_valid) && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        chk({tag, " latency"}, W'(lat), 3);
        chk({tag, " data"}, rsp_data, v.d);
        chk({tag, " z"}, W'(rsp_z), W'(v.z));
        chk({tag, " other_valid"}, W'(v.port ? rsp0_valid : rsp1_valid), 0);
        if (v.port) rsp1_ready = 1; else rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        chk({tag, " idle_rsp"}, W'({rsp0_valid, rsp1_valid}), 0);
    endtask

    vec_t vecs[9];
    logic g[$];
    int gc[$], rc[$];
    logic [W-1:0] rd[$];
    logic exp_g[4];
    logic [W-1:0] exp_d[4];

    initial begin
        vecs[0] = '{0, 3'b000, 20, 30, 50, 0};
        vecs[1] = '{1, 3'b001, 8, 3, 5, 0};
        vecs[2] = '{1, 3'b001, 20, 20, 0, 1};
        vecs[3] = '{0, 3'b101, 20, 30, 1, 0};
        vecs[4] = '{0, 3'b010, 12, 10, 8, 0};
        vecs[5] = '{1, 3'b011, 12, 3, 15, 0};
        vecs[6] = '{0, 3'b101, 30, 20, 0, 1};
        vecs[7] = '{1, 3'b001, 0, 1, 32'hffff_ffff, 0};
        vecs[8] = '{0, 3'b110, 7, 9, 0, 1};

        // reset state, with a request pending
        req0_valid = 1;
        #12;
        chk("rst req0_ready", W'(req0_ready), 0);
        chk("rst rsp_valid", W'({rsp0_valid, rsp1_valid}), 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst rsp_z", W'(rsp_z), 0);
        chk("rst alu_rs1", alu_rs1, 0);
        chk("rst alu_rs2", alu_rs2, 0);
        chk("rst alu_ctrl", W'(alu_ctrl), 0);
        @(negedge clk);
        req0_valid = 0;
        rst_n = 1;

        for (int i = 0; i < 9; i++) do_op(vecs[i], $sformatf("vec%0d", i));

        // backpressure on port 0 while port 1 waits
        @(negedge clk);
        drive_req(0, 3'b010, 20, 30);
        #1;
        chk("bp accept0", W'(req0_ready), 1);
        @(negedge clk);
        req0_valid = 0;
        drive_req(1, 3'b011, 20, 30);
        #1;
        chk("bp issue req1_ready", W'(req1_ready), 0);
        for (int n = 0; n < 20 && !rsp0_valid; n++) begin
            @(negedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            rsp1_ready = 1;
            #1;
            chk($sformatf("bp hold%0d valid", i), W'(rsp0_valid), 1);
            chk($sformatf("bp hold%0d data", i), rsp_data, 20);
            chk($sformatf("bp hold%0d req1_ready", i), W'(req1_ready), 0);
            chk($sformatf("bp hold%0d rsp1_valid", i), W'(rsp1_valid), 0);
            @(negedge clk);
        end
        rsp1_ready = 0;
        rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0;
        #1;
        chk("bp req1 accept next", W'(req1_ready), 1);
        @(negedge clk);
        req1_valid = 0;
        for (int n = 0; n < 20 && !rsp1_valid; n++) begin
            @(negedge clk); #1;
        end
        chk("bp rsp1_valid", W'(rsp1_valid), 1);
        chk("bp rsp1 data", rsp_data, 30);
        rsp1_ready = 1;
        @(negedge clk);
        rsp1_ready = 0;

        // reset in the middle of an op
        @(negedge clk);
        drive_req(0, 3'b001, 5, 6);
        #1;
        chk("mid accept", W'(req0_ready), 1);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1;
        #1;
        rst_n = 0;
        #1;
        chk("mid alu_rs1", alu_rs1, 0);
        chk("mid alu_rs2", alu_rs2, 0);
        chk("mid alu_ctrl", W'(alu_ctrl), 0);
        chk("mid rsp_data", rsp_data, 0);
        chk("mid rsp_valid", W'({rsp0_valid, rsp1_valid}), 0);
        chk("mid req1_ready", W'(req1_ready), 0);
        @(negedge clk);
        rst_n = 1;
        req1_valid = 0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                #1;
                if (rsp0_valid) seen++;
                @(negedge clk);
            end
            chk("mid no rsp", W'(seen), 0);
        end

        // both requesters valid continuously, responses accepted at once
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
        exp_d = '{3, 3, 3, 3};
`else
        exp_g = '{0, 1, 0, 1};
        exp_d = '{3, 6, 3, 6};
`endif
        drive_req(0, 3'b000, 1, 2);
        drive_req(1, 3'b001, 10, 4);
        rsp0_ready = 1;
        rsp1_ready = 1;
        for (int c = 0; c < 17; c++) begin
            #1;
            if (req0_ready) begin g.push_back(0); gc.push_back(c); end
            if (req1_ready) begin g.push_back(1); gc.push_back(c); end
            if (rsp0_valid | rsp1_valid) begin rd.push_back(rsp_data); rc.push_back(c); end
            @(negedge clk);
            if (g.size() == 4) begin req0_valid = 0; req1_valid = 0; end
        end
        rsp0_ready = 0;
        rsp1_ready = 0;
        chk("rr grant count", W'(g.size()), 4);
        chk("rr rsp count", W'(rd.size()), 4);
        if (g.size() == 4 && rd.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr grant%0d", i), W'(g[i]), W'(exp_g[i]));
                chk($sformatf("rr grant%0d cycle", i), W'(gc[i]), W'(4 * i));
                chk($sformatf("rr rsp%0d data", i), rd[i], exp_d[i]);
                chk($sformatf("rr rsp%0d cycle", i), W'(rc[i]), W'(4 * i + 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
